// File: rtl/round_robin_stream_merge_2.sv
// round_robin_stream_merge_2: round-robin merge of two valid/ready streams into one registered output
module round_robin_stream_merge_2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    output logic [1:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);
    logic       ptr;
    logic       can_load;
    logic [1:0] grant;

    // The register may reload in the same cycle the sink drains it.
    assign can_load = ~out_valid | out_ready;
    assign grant[0] = in_valid[0] & (~in_valid[1] | ~ptr);
    assign grant[1] = in_valid[1] & (~in_valid[0] | ptr);
    assign in_ready = grant & {2{can_load}};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            ptr       <= 1'b0;
        end else if (can_load) begin
            out_valid <= |in_ready;
            if (|in_ready) begin
                out_data <= in_ready[1] ? in_data1 : in_data0;
                out_src  <= in_ready[1];
                ptr      <= ~in_ready[1];
            end
        end
    end
endmodule

// File: tb/tb_round_robin_stream_merge_2.sv
// tb_round_robin_stream_merge_2: directed checks of arbitration, back-pressure, throughput, reset and drain
module tb_round_robin_stream_merge_2;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] in_valid = 2'b00;
    logic [7:0] in_data0 = 8'h00;
    logic [7:0] in_data1 = 8'h00;
    logic [1:0] in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_src;
    logic       out_ready = 1'b0;
    int pass = 0;
    int total = 0;

    logic [1:0] arb_v   [10] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
    logic       arb_src [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    round_robin_stream_merge_2 #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data0(in_data0), .in_data1(in_data1),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 2'b00;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 2'b11;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass++;
            total++; if (out_data !== 8'h00) $display("FAIL reset_data got %h want 00", out_data); else pass++;
            total++; if (out_src !== 1'b0) $display("FAIL reset_src got %b want 0", out_src); else pass++;
        end
        rst = 1'b0;
        in_data0 = 8'h11;
        in_data1 = 8'h22;
        #1;
        total++; if (in_ready !== 2'b01) $display("FAIL reset_first_grant got %b want 01", in_ready); else pass++;
        tick();
        total++; if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 8'h11)
            $display("FAIL reset_first_xfer got v=%b s=%b d=%h want v=1 s=0 d=11", out_valid, out_src, out_data); else pass++;
    endtask

    task automatic test_arbitration();
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = arb_v[c];
            in_data0 = 8'hA0 + 8'(c);
            in_data1 = 8'hB0 + 8'(c);
            tick();
            total++;
            if (out_valid !== (arb_v[c] != 2'b00))
                $display("FAIL arb_valid[%0d] got %b want %b", c, out_valid, arb_v[c] != 2'b00);
            else if (out_valid && (out_src !== arb_src[c] || out_data !== (arb_src[c] ? 8'hB0 + 8'(c) : 8'hA0 + 8'(c))))
                $display("FAIL arb_payload[%0d] got s=%b d=%h want s=%b d=%h", c, out_src, out_data,
                         arb_src[c], arb_src[c] ? 8'hB0 + 8'(c) : 8'hA0 + 8'(c));
            else pass++;
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        in_valid = 2'b11;
        in_data0 = 8'h11;
        in_data1 = 8'h22;
        tick();
        total++; if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 8'h11)
            $display("FAIL bp_first got v=%b s=%b d=%h want v=1 s=0 d=11", out_valid, out_src, out_data); else pass++;
        for (int c = 0; c < 3; c++) begin
            total++; if (in_ready !== 2'b00) $display("FAIL bp_in_ready[%0d] got %b want 00", c, in_ready); else pass++;
            tick();
            total++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_src !== 1'b0)
                $display("FAIL bp_hold[%0d] got v=%b s=%b d=%h want v=1 s=0 d=11", c, out_valid, out_src, out_data); else pass++;
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 2'b10) $display("FAIL bp_release_grant got %b want 10", in_ready); else pass++;
        tick();
        total++; if (out_valid !== 1'b1 || out_src !== 1'b1 || out_data !== 8'h22)
            $display("FAIL bp_release_xfer got v=%b s=%b d=%h want v=1 s=1 d=22", out_valid, out_src, out_data); else pass++;
    endtask

    task automatic test_back_to_back();
        int n0 = 0;
        int n1 = 0;
        do_reset();
        in_valid = 2'b11;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_data0 = 8'h40 + 8'(c);
            in_data1 = 8'h80 + 8'(c);
            tick();
            total++;
            if (out_valid !== 1'b1 || out_src !== 1'(c) || out_data !== ((c % 2) ? 8'h80 + 8'(c) : 8'h40 + 8'(c)))
                $display("FAIL b2b[%0d] got v=%b s=%b d=%h want v=1 s=%0d d=%h", c, out_valid, out_src, out_data,
                         c % 2, (c % 2) ? 8'h80 + 8'(c) : 8'h40 + 8'(c));
            else pass++;
            if (out_valid === 1'b1 && out_src === 1'b0) n0++;
            if (out_valid === 1'b1 && out_src === 1'b1) n1++;
        end
        total++; if (n0 != 4 || n1 != 4) $display("FAIL b2b_counts got %0d/%0d want 4/4", n0, n1); else pass++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        in_valid = 2'b11;
        in_data0 = 8'h33;
        in_data1 = 8'h44;
        tick();
        total++; if (out_valid !== 1'b1 || out_src !== 1'b0) $display("FAIL rms_load got v=%b s=%b want v=1 s=0", out_valid, out_src); else pass++;
        rst = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 1'b0)
            $display("FAIL rms_reset got v=%b s=%b d=%h want v=0 s=0 d=00", out_valid, out_src, out_data); else pass++;
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 2'b01) $display("FAIL rms_grant got %b want 01", in_ready); else pass++;
        tick();
        total++; if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 8'h33)
            $display("FAIL rms_xfer got v=%b s=%b d=%h want v=1 s=0 d=33", out_valid, out_src, out_data); else pass++;
    endtask

    task automatic test_drain();
        do_reset();
        out_ready = 1'b1;
        in_valid = 2'b01;
        in_data0 = 8'h5C;
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 8'h5C) $display("FAIL drain_load got v=%b d=%h want v=1 d=5c", out_valid, out_data); else pass++;
        in_valid = 2'b00;
        in_data0 = 8'hEE;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if (out_valid !== 1'b0 || out_data !== 8'h5C || out_src !== 1'b0)
                $display("FAIL drain_idle[%0d] got v=%b s=%b d=%h want v=0 s=0 d=5c", c, out_valid, out_src, out_data); else pass++;
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_arbitration();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid_stall();
        test_drain();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
